// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache controller: FSM state
// encoding and helpers that derive address field widths from parameters.
package icache_pkg;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_LOOKUP   = 3'd2,
    ST_MEM_REQ  = 3'd3,
    ST_MEM_WAIT = 3'd4
  } state_e;

  // Ceiling log2 usable in constant expressions.
  function automatic int clog2_int(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Byte-offset bits inside one cache line.
  function automatic int off_w(input int line_width);
    return clog2_int(line_width / 8);
  endfunction

  // Index bits selecting one of the lines.
  function automatic int idx_w(input int num_lines);
    return clog2_int(num_lines);
  endfunction

  // Byte-offset bits inside one CPU word.
  function automatic int byte_w(input int word_width);
    return clog2_int(word_width / 8);
  endfunction

  // Word-select bits inside one cache line.
  function automatic int wsel_w(input int line_width, input int word_width);
    return off_w(line_width) - byte_w(word_width);
  endfunction

  // Tag bits: whatever remains above index and offset.
  function automatic int tag_w(input int addr_width, input int num_lines, input int line_width);
    return addr_width - idx_w(num_lines) - off_w(line_width);
  endfunction

endpackage

// File: rtl/cache_line.sv
// One cache line storage element: valid bit, tag and data. Storage has no
// reset; the controller clears valid bits with an explicit sweep.
module cache_line #(
  parameter int TAG_WIDTH  = 26,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  write,
  input  logic                  valid_in,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [TAG_WIDTH-1:0]  tag_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic                  valid_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [DATA_WIDTH-1:0] data_q;

  // Capture the whole line when the controller selects this entry.
  always_ff @(posedge clk) begin
    if (write) begin
      valid_q <= valid_in;
      tag_q   <= tag_in;
      data_q  <= data_in;
    end
  end

  assign valid_out = valid_q;
  assign tag_out   = tag_q;
  assign data_out  = data_q;

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller. Owns NUM_LINES
// cache_line entries, serves CPU fetches, fills misses from memory through
// a valid/ready request and a valid-only response, and sweeps all valid
// bits clear after reset and on flush.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int NUM_LINES  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  output logic [WORD_WIDTH-1:0] resp_data,
  input  logic                  flush,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [LINE_WIDTH-1:0] mem_resp_data
);

  localparam int OFF_W  = off_w(LINE_WIDTH);
  localparam int IDX_W  = idx_w(NUM_LINES);
  localparam int TAG_W  = tag_w(ADDR_WIDTH, NUM_LINES, LINE_WIDTH);
  localparam int BYTE_W = byte_w(WORD_WIDTH);
  localparam int WORDS  = LINE_WIDTH / WORD_WIDTH;

  // Extract the addressed word from a line; the loop form also covers a
  // line that holds a single word.
  function automatic logic [WORD_WIDTH-1:0] pick_word(
    input logic [LINE_WIDTH-1:0] line,
    input logic [ADDR_WIDTH-1:0] addr
  );
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [WORD_WIDTH-1:0] word;
    word_idx = (addr >> BYTE_W) & ADDR_WIDTH'(WORDS - 1);
    word     = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (word_idx == ADDR_WIDTH'(i)) begin
        word = line[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
    return word;
  endfunction

  // Controller state.
  state_e                state_q,         state_d;
  logic [IDX_W-1:0]      cnt_q,           cnt_d;
  logic                  flush_pend_q,    flush_pend_d;
  logic [ADDR_WIDTH-1:0] addr_q,          addr_d;
  logic                  resp_valid_q,    resp_valid_d;
  logic [WORD_WIDTH-1:0] resp_data_q,     resp_data_d;
  logic                  mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_WIDTH-1:0] mem_req_addr_q,  mem_req_addr_d;

  // Line storage interface.
  logic                  line_valid_s [NUM_LINES];
  logic [TAG_W-1:0]      line_tag_s   [NUM_LINES];
  logic [LINE_WIDTH-1:0] line_data_s  [NUM_LINES];
  logic [NUM_LINES-1:0]  line_we_s;
  logic                  line_valid_in_s;
  logic [TAG_W-1:0]      line_tag_in_s;
  logic [LINE_WIDTH-1:0] line_data_in_s;

  // Address fields of the incoming request and of the latched request.
  logic [IDX_W-1:0]      req_idx_s;
  logic [TAG_W-1:0]      req_tag_s;
  logic [IDX_W-1:0]      lat_idx_s;
  logic [TAG_W-1:0]      lat_tag_s;
  logic                  pre_hit_s;
  logic [WORD_WIDTH-1:0] pre_word_s;

  assign req_idx_s = req_addr[OFF_W +: IDX_W];
  assign req_tag_s = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign lat_idx_s = addr_q[OFF_W +: IDX_W];
  assign lat_tag_s = addr_q[ADDR_WIDTH-1 -: TAG_W];

  // The hit compare runs on the request address while it is being accepted.
  // Nothing writes the storage in IDLE, so the result equals a compare done
  // in LOOKUP, and the response leaves a register in the LOOKUP cycle.
  assign pre_hit_s  = line_valid_s[req_idx_s] && (line_tag_s[req_idx_s] == req_tag_s);
  assign pre_word_s = pick_word(line_data_s[req_idx_s], req_addr);

  generate
    for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
      cache_line #(
        .TAG_WIDTH  (TAG_W),
        .DATA_WIDTH (LINE_WIDTH)
      ) u_line (
        .clk       (clk),
        .write     (line_we_s[g]),
        .valid_in  (line_valid_in_s),
        .tag_in    (line_tag_in_s),
        .data_in   (line_data_in_s),
        .valid_out (line_valid_s[g]),
        .tag_out   (line_tag_s[g]),
        .data_out  (line_data_s[g])
      );
    end
  endgenerate

  // Next-state logic, registered-output values and line write control.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    resp_valid_d    = 1'b0;
    resp_data_d     = '0;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    line_we_s       = '0;
    line_valid_in_s = 1'b0;
    line_tag_in_s   = lat_tag_s;
    line_data_in_s  = mem_resp_data;

    // A flush outside IDLE is remembered and served on the next IDLE.
    if (flush && (state_q != ST_IDLE)) begin
      flush_pend_d = 1'b1;
    end else begin
      flush_pend_d = flush_pend_q;
    end

    case (state_q)
      ST_INIT: begin
        line_we_s[cnt_q] = 1'b1;
        cnt_d            = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(NUM_LINES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_INIT;
        end
      end

      ST_IDLE: begin
        if (flush || flush_pend_q) begin
          flush_pend_d = 1'b0;
          cnt_d        = '0;
          state_d      = ST_INIT;
        end else if (req_valid) begin
          addr_d       = req_addr;
          resp_valid_d = pre_hit_s;
          if (pre_hit_s) begin
            resp_data_d = pre_word_s;
          end else begin
            resp_data_d = '0;
          end
          state_d = ST_LOOKUP;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOOKUP: begin
        // resp_valid_q carries this cycle's hit decision.
        if (resp_valid_q) begin
          state_d = ST_IDLE;
        end else begin
          mem_req_valid_d = 1'b1;
          mem_req_addr_d  = {lat_tag_s, lat_idx_s, {OFF_W{1'b0}}};
          state_d         = ST_MEM_REQ;
        end
      end

      ST_MEM_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = ST_MEM_WAIT;
        end else begin
          state_d = ST_MEM_REQ;
        end
      end

      ST_MEM_WAIT: begin
        if (mem_resp_valid) begin
          line_we_s[lat_idx_s] = 1'b1;
          line_valid_in_s      = 1'b1;
          // The following LOOKUP is a guaranteed hit on the line just
          // written, so its response is prepared from the fill data.
          resp_valid_d = 1'b1;
          resp_data_d  = pick_word(mem_resp_data, addr_q);
          state_d      = ST_LOOKUP;
        end else begin
          state_d = ST_MEM_WAIT;
        end
      end

      default: begin
        cnt_d           = '0;
        mem_req_valid_d = 1'b0;
        state_d         = ST_INIT;
      end
    endcase
  end

  // State and output registers; reset restarts the invalidate sweep.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_INIT;
      cnt_q           <= '0;
      flush_pend_q    <= 1'b0;
      addr_q          <= '0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      flush_pend_q    <= flush_pend_d;
      addr_q          <= addr_d;
      resp_valid_q    <= resp_valid_d;
      resp_data_q     <= resp_data_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
    end
  end

  // Requests are refused while a flush is arriving or waiting.
  assign req_ready     = (state_q == ST_IDLE) && !flush && !flush_pend_q;
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped, read-only cache controller that owns NUM_LINES instances of the existing cache_line storage element and drives their write, valid_in, tag_in and data_in inputs.
- Sits between the fetch stage (CPU side) and the memory/arbiter port (line-fill side).
- Performs lookup, miss fill through a valid/ready request and valid-only response, post-reset initialisation and flush-invalidate.
- Tag/data storage has no reset, so valid bits are cleared by an explicit INIT sweep.

Parameters:
- ADDR_WIDTH, 32: byte address width.
- WORD_WIDTH, 32: CPU response width.
- LINE_WIDTH, 128: bits per cache line. Must be a power-of-two multiple of WORD_WIDTH.
- NUM_LINES, 4: number of lines. Power of two, ≥2.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  CPU fetch request
- req_ready  output  1  controller can accept a request
- req_addr  input  ADDR_WIDTH  byte address, word aligned
- resp_valid  output  1  one-cycle pulse, resp_data valid
- resp_data  output  WORD_WIDTH  fetched word
- flush  input  1  invalidate-all request
- mem_req_valid  output  1  line fill request
- mem_req_ready  input  1  memory accepts request
- mem_req_addr  output  ADDR_WIDTH  line-aligned address (offset bits = 0)
- mem_resp_valid  input  1  fill data valid, single cycle
- mem_resp_data  input  LINE_WIDTH  fill line

Behaviour:
- Address split:
  - OFF_W = log2(LINE_WIDTH/8).
  - IDX_W = log2(NUM_LINES).
  - TAG_W = ADDR_WIDTH − IDX_W − OFF_W.
  - Word select = addr[OFF_W-1 : log2(WORD_WIDTH/8)].
  - Defaults: OFF_W=4, IDX_W=2, TAG_W=26.
- States: INIT, IDLE, LOOKUP, MEM_REQ, MEM_WAIT.
- Reset (reset=0, asynchronous):
  - state=INIT, init counter=0, flush_pend=0, latched addr=0.
  - Outputs: req_ready=0, resp_valid=0, resp_data=0, mem_req_valid=0, mem_req_addr=0.
- INIT:
  - Each cycle, write line[counter] with valid_in=0; counter increments.
  - After the write of index NUM_LINES−1, go to IDLE.
  - Takes exactly NUM_LINES cycles. req_ready=0 throughout.
- IDLE:
  - req_ready = !flush && !flush_pend.
  - If flush or flush_pend: clear flush_pend, counter=0, go to INIT. Any request that cycle is not accepted.
  - Else if req_valid: latch req_addr, go to LOOKUP.
- LOOKUP (req_ready=0):
  - Hit = line[idx].valid_out && line[idx].tag_out == tag.
  - On hit: resp_valid=1 and resp_data=selected word for this cycle only, then go to IDLE.
  - On miss: go to MEM_REQ.
  - Hit latency: response in the cycle after acceptance. Throughput: 1 request per 2 cycles.
- MEM_REQ:
  - mem_req_valid=1, mem_req_addr={tag, idx, OFF_W'0}, both held stable until mem_req_ready.
  - On valid&&ready, go to MEM_WAIT with mem_req_valid=0 the next cycle.
- MEM_WAIT:
  - On mem_resp_valid: write line[idx] with valid=1, tag, mem_resp_data, then go to LOOKUP, which hits.
  - Miss response arrives 1 cycle after the fill cycle.
  - mem_resp_valid outside MEM_WAIT is ignored.
- flush asserted in any state other than IDLE sets flush_pend (sticky).
  - An in-flight miss completes and returns its response first.
  - The INIT sweep then runs on return to IDLE.
- At most one outstanding memory request. Never more than one cache_line write per cycle.
- reset asserted mid-fill:
  - Everything returns to INIT immediately.
  - A late mem_resp_valid after reset is ignored.
  - The memory side is reset on the same reset.

Decomposition:
- Shared package icache_pkg:
  - state enum (INIT, IDLE, LOOKUP, MEM_REQ, MEM_WAIT).
  - localparam functions deriving OFF_W/IDX_W/TAG_W/word-select width from the parameters.
- Sub-module: the existing cache_line, instantiated NUM_LINES times in a generate loop, with TAG_WIDTH=TAG_W and DATA_WIDTH=LINE_WIDTH.
- No further sub-modules. Hit compare and word mux stay inline.

Test Plan:
- Release reset, idle inputs → req_ready=0 for exactly 4 cycles, then 1; an immediate read of 0x0000_0010 misses (mem_req_valid=1, mem_req_addr=0x10).
- Miss fill:
  - Stimulus: read 0x0000_1024; mem_req_ready held low 3 cycles; mem_resp_data = {0xDDDD_DDDD, 0xCCCC_CCCC, 0xBBBB_BBBB, 0xAAAA_AAAA} (word3..word0).
  - Response: mem_req_addr stays 0x0000_1020 until accepted; resp_valid pulses once with resp_data=0xBBBB_BBBB.
- Hit: repeat read 0x0000_102C → resp_valid one cycle after acceptance, data 0xDDDD_DDDD, mem_req_valid stays 0.
- Conflict: read 0x0000_1060 (same idx=2, different tag) → miss, refill; a subsequent read of 0x0000_1020 misses again.
- Flush during MEM_WAIT:
  - Stimulus: pulse flush during MEM_WAIT.
  - Response: the pending response is still delivered; then 4 INIT cycles with req_ready=0; a re-read of the same address misses.
- Reset asserted in MEM_WAIT, then mem_resp_valid arrives → all outputs 0 during reset; no resp_valid; next read of that address misses.
